// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central hazard controller for the 5-stage MIPS pipeline.
//               Produces PC / pipeline-register write enables, bubble and
//               flush strobes and the PC redirect select. Handles load-use
//               stalls, branch/jump flushes and data-memory wait states with
//               a timeout, and keeps saturating stall / redirect counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,   // IF/ID flush cycles per redirect (1..7)
    parameter int MEM_TIMEOUT  = 15,  // max MEM_WAIT cycles before abort (1..255)
    parameter int CNT_W        = 16   // performance counter width
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             pc_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Remaining-flush reload value and timeout threshold at counter widths
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_VAL  = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [2:0]       flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic             load_use;
    logic             mem_stall;
    logic             stall_inc;
    logic             flush_inc;

    // Counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // The ID instruction needs a register that the load in ID/EX has not yet
    // fetched; $zero is never a real dependency.
    assign load_use  = idex_memread && (idex_rt != 5'd0) &&
                       ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    assign mem_stall = dmem_req && !dmem_ready;

    // Next-state, counter-increment and pipeline-control decode
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        flush_left_d = flush_left_q;
        mem_err_d    = mem_err_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        pc_sel       = 1'b0;

        // While reset is held the pipeline free-runs with no strobes
        if (RST) begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_write = 1'b0;
                        state_d     = MEM_WAIT;
                        wait_cnt_d  = 8'd1;
                        stall_inc   = 1'b1;
                    end else if (ex_redirect) begin
                        // Redirect squashes the ID instruction, so any
                        // load-use hazard on it is moot.
                        pc_sel     = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        flush_inc  = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d      = FLUSH;
                            flush_left_d = FLUSH_RELOAD;
                        end
                    end else if (load_use) begin
                        // One bubble: the load moves on next cycle and the
                        // hazard disappears by itself.
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end

                MEM_WAIT: begin
                    if (dmem_ready) begin
                        // Release only; redirect/load-use inputs are frozen
                        // and get evaluated again next cycle in RUN.
                        state_d    = RUN;
                        wait_cnt_d = 8'd0;
                    end else if (wait_cnt_q >= TIMEOUT_VAL) begin
                        mem_err_d  = 1'b1;
                        state_d    = RUN;
                        wait_cnt_d = 8'd0;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_write  = 1'b0;
                        exmem_write = 1'b0;
                        stall_inc   = 1'b1;
                        wait_cnt_d  = wait_cnt_q + 8'd1;
                    end
                end

                FLUSH: begin
                    if (mem_stall) begin
                        // Memory wait wins; leftover flush cycles are dropped
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_write  = 1'b0;
                        state_d      = MEM_WAIT;
                        wait_cnt_d   = 8'd1;
                        flush_left_d = 3'd0;
                        stall_inc    = 1'b1;
                    end else begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        if (ex_redirect) begin
                            pc_sel       = 1'b1;
                            flush_left_d = FLUSH_RELOAD;
                            flush_inc    = 1'b1;
                        end else if (flush_left_q <= 3'd1) begin
                            state_d      = RUN;
                            flush_left_d = 3'd0;
                        end else begin
                            flush_left_d = flush_left_q - 3'd1;
                        end
                    end
                end

                default: begin
                    state_d = RUN;
                end
            endcase
        end

        stall_cnt_d = stall_inc ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_inc ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // State, wait/flush counters, performance counters and error flag
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= RUN;
            wait_cnt_q   <= 8'd0;
            flush_left_q <= 3'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_left_q <= flush_left_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. Instance A uses
//               FLUSH_CYCLES=1 / MEM_TIMEOUT=4, instance B FLUSH_CYCLES=3 with
//               3-bit counters for multi-cycle flush and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, pc_sel}
    localparam logic [6:0] O_NORM = 7'b1101010;
    localparam logic [6:0] O_LU   = 7'b0001110;
    localparam logic [6:0] O_RED  = 7'b1111111;
    localparam logic [6:0] O_FRZ  = 7'b0000000;
    localparam logic [6:0] O_FL   = 7'b1111110;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
    logic       id_uses_rt = 1'b0, idex_memread = 1'b0, ex_redirect = 1'b0;
    logic       dmem_req = 1'b0, dmem_ready = 1'b0;

    logic        a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write;
    logic        a_idex_flush, a_exmem_write, a_pc_sel, a_mem_err;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idex_write;
    logic        b_idex_flush, b_exmem_write, b_pc_sel, b_mem_err;
    logic [2:0]  b_stall_cnt, b_flush_cnt;

    logic [6:0] a_outs, b_outs;
    assign a_outs = {a_pc_write, a_ifid_write, a_ifid_flush, a_idex_write,
                     a_idex_flush, a_exmem_write, a_pc_sel};
    assign b_outs = {b_pc_write, b_ifid_write, b_ifid_flush, b_idex_write,
                     b_idex_flush, b_exmem_write, b_pc_sel};

    int n_cmp = 0;
    int n_err = 0;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(16)) u_dut_a (
        .CLK(CLK), .RST(RST),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(a_pc_write), .ifid_write(a_ifid_write), .ifid_flush(a_ifid_flush),
        .idex_write(a_idex_write), .idex_flush(a_idex_flush),
        .exmem_write(a_exmem_write), .pc_sel(a_pc_sel), .mem_err(a_mem_err),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(3)) u_dut_b (
        .CLK(CLK), .RST(RST),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(b_pc_write), .ifid_write(b_ifid_write), .ifid_flush(b_ifid_flush),
        .idex_write(b_idex_write), .idex_flush(b_idex_flush),
        .exmem_write(b_exmem_write), .pc_sel(b_pc_sel), .mem_err(b_mem_err),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       memrd;
        logic [4:0] xrt;
        logic       redir;
        logic       req;
        logic       rdy;
        logic [6:0] outs;
        int         stall;
        int         flush;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge
    task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                         input logic memrd, input logic [4:0] xrt, input logic redir,
                         input logic req, input logic rdy);
        @(negedge CLK);
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = use_rt;
        idex_memread = memrd;
        idex_rt      = xrt;
        ex_redirect  = redir;
        dmem_req     = req;
        dmem_ready   = rdy;
    endtask

    task automatic idle();
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check A's comb outputs mid-cycle, then let the edge happen
    task automatic step_a(input string name, input logic [6:0] exp);
        #1 check(name, {25'd0, a_outs}, {25'd0, exp});
        @(posedge CLK);
        #1;
    endtask

    task automatic step_b(input string name, input logic [6:0] exp);
        #1 check(name, {25'd0, b_outs}, {25'd0, exp});
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        id_rs = '0; id_rt = '0; idex_rt = '0; id_uses_rt = 1'b0;
        idex_memread = 1'b0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        //                 rs     rt     use   memrd xrt    redir req   rdy   outs    stall flush
        vecs[0]  = '{5'd2,  5'd4,  1'b1, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, O_LU,   1, 0};
        vecs[1]  = '{5'd3,  5'd4,  1'b1, 1'b0, 5'd2,  1'b0, 1'b0, 1'b0, O_NORM, 1, 0};
        vecs[2]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, O_NORM, 1, 0};
        vecs[3]  = '{5'd1,  5'd7,  1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, O_NORM, 1, 0};
        vecs[4]  = '{5'd1,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, O_LU,   2, 0};
        vecs[5]  = '{5'd9,  5'd1,  1'b0, 1'b0, 5'd9,  1'b0, 1'b0, 1'b0, O_NORM, 2, 0};
        vecs[6]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, O_RED,  2, 1};
        vecs[7]  = '{5'd2,  5'd4,  1'b1, 1'b1, 5'd2,  1'b1, 1'b0, 1'b0, O_RED,  2, 2};
        vecs[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1, O_NORM, 2, 2};
        vecs[9]  = '{5'd5,  5'd6,  1'b1, 1'b1, 5'd6,  1'b0, 1'b1, 1'b1, O_LU,   3, 2};
        vecs[10] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_NORM, 3, 2};
        vecs[11] = '{5'd31, 5'd0,  1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, O_LU,   4, 2};

        // Reset held with every hazard input active: outputs stay benign
        id_rs = 5'd2; idex_rt = 5'd2; idex_memread = 1'b1;
        ex_redirect = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
        #2;
        check("rst_outs_a", {25'd0, a_outs}, {25'd0, O_NORM});
        check("rst_outs_b", {25'd0, b_outs}, {25'd0, O_NORM});
        repeat (2) @(posedge CLK);
        #1;
        check("rst_stall_a", {16'd0, a_stall_cnt}, 32'd0);
        check("rst_flush_a", {16'd0, a_flush_cnt}, 32'd0);
        check("rst_err_a",   {31'd0, a_mem_err}, 32'd0);
        check("rst_err_b",   {31'd0, b_mem_err}, 32'd0);
        do_reset();

        // Single-cycle RUN vectors
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rs, vecs[i].rt, vecs[i].use_rt, vecs[i].memrd, vecs[i].xrt,
                  vecs[i].redir, vecs[i].req, vecs[i].rdy);
            step_a($sformatf("vec%0d_outs", i), vecs[i].outs);
            check($sformatf("vec%0d_stall", i), {16'd0, a_stall_cnt}, 32'(vecs[i].stall));
            check($sformatf("vec%0d_flush", i), {16'd0, a_flush_cnt}, 32'(vecs[i].flush));
            check($sformatf("vec%0d_err", i),   {31'd0, a_mem_err}, 32'd0);
        end

        // Memory wait: 3 frozen cycles, redirect ignored while waiting
        do_reset();
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step_a("mw_frz1", O_FRZ);
        apply(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        step_a("mw_frz2_redir", O_FRZ);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step_a("mw_frz3", O_FRZ);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        step_a("mw_release", O_NORM);
        check("mw_stall", {16'd0, a_stall_cnt}, 32'd3);
        check("mw_flush", {16'd0, a_flush_cnt}, 32'd0);
        idle();
        step_a("mw_back_run", O_NORM);
        apply(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        step_a("mw_run_lu", O_LU);

        // Timeout: ready never arrives
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            step_a($sformatf("to_frz%0d", k), O_FRZ);
        end
        check("to_err_before", {31'd0, a_mem_err}, 32'd0);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step_a("to_release", O_NORM);
        check("to_err_set", {31'd0, a_mem_err}, 32'd1);
        check("to_stall", {16'd0, a_stall_cnt}, 32'd4);
        idle();
        step_a("to_idle", O_NORM);
        check("to_err_sticky", {31'd0, a_mem_err}, 32'd1);

        // Reset pulse in the middle of a memory wait
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step_a("rm_frz1", O_FRZ);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        #1 check("rm_frz2", {25'd0, a_outs}, {25'd0, O_FRZ});
        #1 RST = 1'b0;
        #1;
        check("rm_outs", {25'd0, a_outs}, {25'd0, O_NORM});
        check("rm_stall", {16'd0, a_stall_cnt}, 32'd0);
        check("rm_err", {31'd0, a_mem_err}, 32'd0);
        @(negedge CLK);
        dmem_req = 1'b0;
        RST = 1'b1;
        idle();
        step_a("rm_after", O_NORM);
        check("rm_stall_after", {16'd0, a_stall_cnt}, 32'd0);

        // Multi-cycle flush on instance B
        do_reset();
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step_b("fl_redir", O_RED);
        idle();
        step_b("fl_c1", O_FL);
        idle();
        step_b("fl_c2", O_FL);
        idle();
        step_b("fl_done", O_NORM);
        check("fl_cnt1", {29'd0, b_flush_cnt}, 32'd1);

        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step_b("fl2_redir", O_RED);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step_b("fl2_reload", O_RED);
        idle();
        step_b("fl2_c1", O_FL);
        idle();
        step_b("fl2_c2", O_FL);
        idle();
        step_b("fl2_done", O_NORM);
        check("fl_cnt3", {29'd0, b_flush_cnt}, 32'd3);

        // Memory stall inside FLUSH discards the rest of the flush
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        step_b("fl3_redir", O_RED);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step_b("fl3_memfrz", O_FRZ);
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step_b("fl3_release", O_NORM);
        idle();
        step_b("fl3_discard", O_NORM);

        // Flush counter saturates at 7 (4 so far + 5)
        for (int k = 0; k < 5; k++) begin
            apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
            step_b($sformatf("sat_redir%0d", k), O_RED);
        end
        check("sat_flush_b", {29'd0, b_flush_cnt}, 32'd7);

        // Stall counter: 10 load-use cycles
        do_reset();
        for (int k = 0; k < 10; k++) begin
            apply(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
            @(posedge CLK);
        end
        #1;
        check("sat_stall_a", {16'd0, a_stall_cnt}, 32'd10);
        check("sat_stall_b", {29'd0, b_stall_cnt}, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
